aer_encoder: RTL

- Downstream stage of the LIF neuron array; converts per-neuron spike pulses into a serial address-event (AER) stream.
- Each spike is latched, arbitrated by fixed priority (lowest index wins) and queued with a timestamp into a FIFO.
- The FIFO drains over a valid/ready handshake to the chip output or readout logic.
- Counts spikes lost to pending-slot collisions.

---
 rtl/aer_encoder.sv | 114 +++++++++++
 1 files changed

// File: rtl/aer_encoder.sv
// Address-event encoder: latches neuron spikes, arbitrates lowest-index-first and
// queues {address, timestamp} events into a show-ahead FIFO drained by valid/ready.
module aer_encoder #(
  parameter int NUM_NEURONS = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int TS_WIDTH    = 8,
  parameter int DROP_WIDTH  = 8,
  localparam int AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int CW = PW + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_NEURONS-1:0] spikes_i,
  output logic                   event_valid_o,
  output logic [AW-1:0]          event_addr_o,
  output logic [TS_WIDTH-1:0]    event_ts_o,
  input  logic                   event_ready_i,
  output logic [CW-1:0]          fifo_count_o,
  output logic [DROP_WIDTH-1:0]  drop_cnt_o
);

  localparam int EW = AW + TS_WIDTH;
  localparam longint unsigned DROP_MAX = (64'd1 << DROP_WIDTH) - 64'd1;

  function automatic int unsigned popcount(input logic [NUM_NEURONS-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

  function automatic logic [DROP_WIDTH-1:0] drop_sat_add(input logic [DROP_WIDTH-1:0] acc,
                                                         input int unsigned inc);
    longint unsigned sum;
    sum = 64'(acc) + 64'(inc);
    if (sum > DROP_MAX) return '1;
    return DROP_WIDTH'(sum);
  endfunction

  logic [NUM_NEURONS-1:0] pending_r;
  logic [TS_WIDTH-1:0]    ts_r;
  logic [PW-1:0]          wr_ptr_r;
  logic [PW-1:0]          rd_ptr_r;
  logic [CW-1:0]          count_r;
  logic [DROP_WIDTH-1:0]  drop_cnt_r;
  logic [EW-1:0]          mem [FIFO_DEPTH];

  logic [NUM_NEURONS-1:0] grant;
  logic [AW-1:0]          grant_idx;
  logic                   found;
  logic                   push_ok;
  logic                   push;
  logic                   pop;
  logic [NUM_NEURONS-1:0] drops;
  logic [EW-1:0]          head;

  // Arbitration on registered state: a pop frees a slot in the same cycle.
  assign event_valid_o = (count_r != '0);
  assign pop           = event_valid_o & event_ready_i;
  assign push_ok       = (count_r < CW'(FIFO_DEPTH)) | pop;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    if (push_ok) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        if (!found && pending_r[k]) begin
          grant[k]  = 1'b1;
          grant_idx = AW'(k);
          found     = 1'b1;
        end
      end
    end
  end

  assign push  = found;
  assign drops = spikes_i & pending_r & ~grant;

  // State update: pending latch, timestamp, FIFO pointers and drop counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_r  <= '0;
      ts_r       <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      drop_cnt_r <= '0;
    end else begin
      pending_r  <= (pending_r & ~grant) | spikes_i;
      ts_r       <= ts_r + TS_WIDTH'(1);
      drop_cnt_r <= drop_sat_add(drop_cnt_r, popcount(drops));
      if (push) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + PW'(1);
      if (push && !pop)      count_r <= count_r + CW'(1);
      else if (pop && !push) count_r <= count_r - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_r] <= {grant_idx, ts_r};
  end

  // Show-ahead head, masked to zero while the FIFO is empty.
  assign head         = mem[rd_ptr_r];
  assign event_addr_o = event_valid_o ? head[EW-1:TS_WIDTH] : '0;
  assign event_ts_o   = event_valid_o ? head[TS_WIDTH-1:0] : '0;
  assign fifo_count_o = count_r;
  assign drop_cnt_o   = drop_cnt_r;

endmodule
